// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between two masters.
// In-order tag FIFO steers each read return back to its issuing master.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 16,
  parameter int BE_W        = 2,
  parameter int MAX_PENDING = 4
) (
  input  logic              SYS_CLK,
  input  logic              user_reset_button,
  input  logic              m0_rd_n,
  input  logic              m0_wr_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [BE_W-1:0]   m0_be_n,
  output logic              m0_wait_req,
  output logic              m0_valid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_rd_n,
  input  logic              m1_wr_n,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [BE_W-1:0]   m1_be_n,
  output logic              m1_wait_req,
  output logic              m1_valid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] az_addr,
  output logic [DATA_W-1:0] az_data,
  output logic [BE_W-1:0]   az_be_n,
  output logic              az_rd_n,
  output logic              az_wr_n,
  input  logic [DATA_W-1:0] za_data,
  input  logic              za_valid,
  input  logic              za_waitrequest,
  output logic [$clog2(MAX_PENDING):0] o_pending,
  output logic              o_unexpected_valid
);

  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_PENDING);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]             state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic [MAX_PENDING-1:0] tag_q, tag_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   unexp_q, unexp_d;

  logic req0, req1, rd0, rd1;
  logic gnt0, gnt1, full, empty;
  logic acc0, acc1, push, pop, head;

  // Write wins when both strobes are low.
  assign req0  = ~m0_rd_n | ~m0_wr_n;
  assign req1  = ~m1_rd_n | ~m1_wr_n;
  assign rd0   = ~m0_rd_n & m0_wr_n;
  assign rd1   = ~m1_rd_n & m1_wr_n;
  assign gnt0  = (state_q == GNT0);
  assign gnt1  = (state_q == GNT1);
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  assign m0_wait_req = ~gnt0 | za_waitrequest | (rd0 & full);
  assign m1_wait_req = ~gnt1 | za_waitrequest | (rd1 & full);
  assign acc0 = gnt0 & req0 & ~m0_wait_req;
  assign acc1 = gnt1 & req1 & ~m1_wait_req;
  assign push = (acc0 & rd0) | (acc1 & rd1);
  assign pop  = za_valid & ~empty;
  assign head = tag_q[rptr_q];

  assign m0_valid = pop & ~head;
  assign m1_valid = pop & head;
  assign m0_rdata = za_data;
  assign m1_rdata = za_data;
  assign o_pending = cnt_q;
  assign o_unexpected_valid = unexp_q;

  always_comb begin
    az_addr = '0;
    az_data = '0;
    az_be_n = '0;
    az_rd_n = 1'b1;
    az_wr_n = 1'b1;
    unique case (1'b1)
      gnt0: begin
        az_addr = m0_addr;
        az_data = m0_wdata;
        az_be_n = m0_be_n;
        az_rd_n = ~(rd0 & ~full);
        az_wr_n = m0_wr_n;
      end
      gnt1: begin
        az_addr = m1_addr;
        az_data = m1_wdata;
        az_be_n = m1_be_n;
        az_rd_n = ~(rd1 & ~full);
        az_wr_n = m1_wr_n;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (1'b1)
      gnt0: begin
        if (acc0) begin
          ptr_d   = 1'b1;
          state_d = req1 ? GNT1 : IDLE;
        end else if (!req0) begin
          state_d = IDLE;
        end
      end
      gnt1: begin
        if (acc1) begin
          ptr_d   = 1'b0;
          state_d = req0 ? GNT0 : IDLE;
        end else if (!req1) begin
          state_d = IDLE;
        end
      end
      default: begin
        if (req0 && req1) state_d = ptr_q ? GNT1 : GNT0;
        else if (req0)    state_d = GNT0;
        else if (req1)    state_d = GNT1;
        else              state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    tag_d  = tag_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      tag_d[wptr_q] = acc1;
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
    unexp_d = unexp_q | (za_valid & empty);
  end

  always_ff @(posedge SYS_CLK or posedge user_reset_button) begin
    if (user_reset_button) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      tag_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      unexp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      unexp_q <= unexp_d;
    end
  end

endmodule
